adder_operand_sequencer: RTL and testbench

//  Upstream/downstream wrapper around adder32. Assembles op1, op2 and op from a narrow byte

---
 rtl/opseq_pkg.sv | 20 ++
 rtl/adder32.sv | 24 ++
 rtl/adder_operand_sequencer.sv | 122 ++++++++++++
 tb/tb_adder_operand_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/opseq_pkg.sv
// Shared types and constants for the adder operand sequencer.
// Carries the FSM state encoding, the beat count per operand and the op codes.
package opseq_pkg;

    localparam int BEATS = 4;
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        DONE    = 3'd4
    } opseq_state_t;

endpackage

// File: rtl/adder32.sv
// Combinational 32-bit add/subtract with signed-overflow flag.
// sub=0 computes a+b, sub=1 computes a-b; sum wraps modulo 2^32.
module adder32 (
    input  logic        sub,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum,
    output logic        flag
);

    logic signed [32:0] a_x;
    logic signed [32:0] b_x;
    logic signed [32:0] r_x;

    // One extra sign bit: overflow shows as the top two bits disagreeing.
    always_comb begin
        a_x  = $signed({a[31], a});
        b_x  = $signed({b[31], b});
        r_x  = sub ? (a_x - b_x) : (a_x + b_x);
        sum  = r_x[31:0];
        flag = r_x[32] ^ r_x[31];
    end

endmodule

// File: rtl/adder_operand_sequencer.sv
// Assembles op1/op2/op from a byte stream, runs them through adder32 and holds the result.
// Optional macro OPSEQ_STICKY_OVF_EN adds the ovf_sticky/ovf_clr overflow accumulator.
module adder_operand_sequencer
    import opseq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IN_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] res_sum,
    output logic              res_flag,
    output logic              out_valid,
    input  logic              out_ready
`ifdef OPSEQ_STICKY_OVF_EN
    ,
    output logic              ovf_sticky,
    input  logic              ovf_clr
`endif
);

    opseq_state_t      state;
    opseq_state_t      state_nxt;
    logic [CNT_W-1:0]  beat_cnt;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic              op_sel;
    logic              beat_take;
    logic              last_beat;
    logic [DATA_W-1:0] add_sum;
    logic              add_flag;

    adder32 u_adder32 (
        .sub  (op_sel),
        .a    (op1),
        .b    (op2),
        .sum  (add_sum),
        .flag (add_flag)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD_A;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        last_beat = (beat_cnt == LAST_BEAT);
        case (state)
            LOAD_A: begin
                in_ready = 1'b1;
                if (in_valid && last_beat) state_nxt = LOAD_B;
            end
            LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid && last_beat) state_nxt = LOAD_OP;
            end
            LOAD_OP: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = EXEC;
            end
            EXEC: state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = LOAD_A;
            end
            default: state_nxt = LOAD_A;
        endcase
        beat_take = in_valid && in_ready;
    end

    // Operands fill from the top so the first beat ends up in the low byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            op1      <= '0;
            op2      <= '0;
            op_sel   <= OP_ADD;
            res_sum  <= '0;
            res_flag <= 1'b0;
        end else begin
            if (beat_take) begin
                case (state)
                    LOAD_A: begin
                        op1      <= {in_data, op1[DATA_W-1:IN_W]};
                        beat_cnt <= last_beat ? '0 : beat_cnt + CNT_W'(1);
                    end
                    LOAD_B: begin
                        op2      <= {in_data, op2[DATA_W-1:IN_W]};
                        beat_cnt <= last_beat ? '0 : beat_cnt + CNT_W'(1);
                    end
                    LOAD_OP: op_sel <= in_data[0];
                    default: ;
                endcase
            end
            if (state == EXEC) begin
                res_sum  <= add_sum;
                res_flag <= add_flag;
            end
        end
    end

`ifdef OPSEQ_STICKY_OVF_EN
    // Clear wins over a same-cycle overflow delivery.
    always_ff @(posedge clk) begin
        if (rst || ovf_clr) begin
            ovf_sticky <= 1'b0;
        end else if (out_valid && out_ready && res_flag) begin
            ovf_sticky <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Self-checking bench for adder_operand_sequencer: directed cases plus randomized operand sets.
// Sticky-overflow checks are compiled in when OPSEQ_STICKY_OVF_EN is defined.
module tb_adder_operand_sequencer;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] res_sum;
    logic        res_flag;
    logic        out_valid;
    logic        out_ready;
`ifdef OPSEQ_STICKY_OVF_EN
    logic        ovf_sticky;
    logic        ovf_clr;
    logic        sticky_m;
`endif

    int n_cmp;
    int n_bad;

    adder_operand_sequencer #(.DATA_W(32), .IN_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .res_sum   (res_sum),
        .res_flag  (res_flag),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef OPSEQ_STICKY_OVF_EN
        ,
        .ovf_sticky(ovf_sticky),
        .ovf_clr   (ovf_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: signed arithmetic in 64 bits, then wrap and range-test.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b, input logic op);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] r;
        logic               ovf;
        sa  = 64'(signed'(a));
        sb  = 64'(signed'(b));
        r   = op ? (sa - sb) : (sa + sb);
        ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        return {ovf, r[31:0]};
    endfunction

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send_beat(input logic [7:0] d, input int gap);
        int n;
        in_valid = 1'b0;
        idle_cycles(gap);
        @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("beat_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Loads a full operand set and checks out_valid latency around the op beat.
    task automatic send_set(input logic [31:0] a, input logic [31:0] b, input logic [7:0] opb, input bit gaps);
        for (int i = 0; i < 4; i++) send_beat(a[8*i +: 8], gaps ? int'($urandom_range(0, 2)) : 0);
        for (int i = 0; i < 4; i++) send_beat(b[8*i +: 8], gaps ? int'($urandom_range(0, 2)) : 0);
        send_beat(opb, gaps ? int'($urandom_range(0, 2)) : 0);
        @(negedge clk);
        chk("exec_out_valid", 64'(out_valid), 64'd0);
        chk("exec_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("lat_out_valid", 64'(out_valid), 64'd1);
    endtask

    // Checks the held result, stalls the sink for 'stall' cycles, then completes the handshake.
    task automatic take_result(input logic [32:0] exp, input int stall, input string tag);
        chk({tag, "_sum"}, 64'(res_sum), 64'(exp[31:0]));
        chk({tag, "_flag"}, 64'(res_flag), 64'(exp[32]));
        out_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || res_sum !== exp[31:0] || in_ready !== 1'b0)
                chk({tag, "_hold"}, {31'd0, out_valid, res_sum, in_ready}, {31'd0, 1'b1, exp[31:0], 1'b0});
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
`ifdef OPSEQ_STICKY_OVF_EN
        if (exp[32]) sticky_m = 1'b1;
        chk({tag, "_sticky"}, 64'(ovf_sticky), 64'(sticky_m));
`endif
        chk({tag, "_post_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_post_ready"}, 64'(in_ready), 64'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`ifdef OPSEQ_STICKY_OVF_EN
        sticky_m = 1'b0;
`endif
    endtask

    logic [31:0] ra;
    logic [31:0] rb;
    logic [7:0]  ropb;
    logic [31:0] corner [4];

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        corner[0] = 32'h0000_0000;
        corner[1] = 32'hFFFF_FFFF;
        corner[2] = 32'h7FFF_FFFF;
        corner[3] = 32'h8000_0000;
`ifdef OPSEQ_STICKY_OVF_EN
        ovf_clr   = 1'b0;
        sticky_m  = 1'b0;
`endif
        do_reset();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_res_sum", 64'(res_sum), 64'd0);
        chk("rst_res_flag", 64'(res_flag), 64'd0);
`ifdef OPSEQ_STICKY_OVF_EN
        chk("rst_sticky", 64'(ovf_sticky), 64'd0);
`endif

        send_set(32'h0000_0005, 32'h0000_0003, 8'h00, 1'b0);
        chk("add_sum", 64'(res_sum), 64'h0000_0008);
        chk("add_flag", 64'(res_flag), 64'd0);
        // Offer a beat while the result is stalled: it must not be consumed.
        in_data  = 8'hA5;
        in_valid = 1'b1;
        take_result(33'h0_0000_0008, 10, "bp");
        in_valid = 1'b0;

        send_set(32'h7FFF_FFFF, 32'h0000_0001, 8'h00, 1'b0);
        take_result({1'b1, 32'h8000_0000}, 0, "ovf_add");

        send_set(32'h8000_0000, 32'h0000_0001, 8'h01, 1'b0);
        take_result({1'b1, 32'h7FFF_FFFF}, 1, "ovf_sub");

        for (int i = 0; i < 4; i++) send_beat(8'hEE, 0);
        for (int i = 0; i < 2; i++) send_beat(8'hDD, 0);
        do_reset();
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        send_set(32'h0000_0001, 32'h0000_0002, 8'h00, 1'b0);
        take_result(33'h0_0000_0003, 0, "midrst");

`ifdef OPSEQ_STICKY_OVF_EN
        send_set(32'h7FFF_FFFF, 32'h0000_0001, 8'h00, 1'b0);
        take_result({1'b1, 32'h8000_0000}, 0, "st_ovf");
        send_set(32'h0000_0005, 32'h0000_0003, 8'h00, 1'b0);
        take_result(33'h0_0000_0008, 0, "st_add");
        chk("sticky_held", 64'(ovf_sticky), 64'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr  = 1'b0;
        sticky_m = 1'b0;
        chk("sticky_clr", 64'(ovf_sticky), 64'd0);
`endif

        for (int t = 0; t < 30; t++) begin
            ra   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            rb   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            ropb = 8'($urandom);
            send_set(ra, rb, ropb, 1'b1);
            take_result(model(ra, rb, ropb[0]), int'($urandom_range(0, 3)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
